// File: rtl/core_batch_sequencer_pkg.sv
// core_batch_sequencer_pkg: shared FSM state encoding and helpers for the batch sequencer.
// Contents: state_e (IDLE..DRAIN), is_busy() mapping a state to the busy output.
package core_batch_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_DRAIN
    } state_e;

    function automatic logic is_busy(input state_e s);
        return s != S_IDLE;
    endfunction

endpackage

// File: rtl/core_batch_sequencer_fifo.sv
// seq_result_fifo: synchronous result FIFO between the sequencer and the result sink.
// Ports: clk, rst (sync, active-high, empties FIFO); push/din write side, gated internally by !full;
//        pop reads the head, ignored while empty; dout is the current head; full/empty status.
module seq_result_fifo #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign full  = cnt_q == CW'(DEPTH);
    assign empty = cnt_q == '0;
    assign dout  = mem_q[rd_q];

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = wr_q + PW'(do_push);
        rd_d    = rd_q + PW'(do_pop);
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/core_batch_sequencer.sv
// core_batch_sequencer: issues one table address per job to the core array, waits for every
// core's end_process flag and queues each job's result for a valid/ready consumer.
// Ports: clk, rst (sync, active-high); start/job_count launch a batch; tbl_we/tbl_waddr/tbl_wdata
//        load the address table while idle; core_addr/core_go drive the cores, core_done/core_result
//        come back; res_data/res_valid/res_ready form the result stream; busy, done (1-cycle), err.
// Optional: define WATCHDOG_EN to bound WAIT by TIMEOUT_CYC cycles and raise a sticky err.
module core_batch_sequencer
    import core_batch_sequencer_pkg::*;
#(
    parameter int N_CORES     = 4,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 12,
    parameter int DEPTH       = 512,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   job_count,
    input  logic                     tbl_we,
    input  logic [$clog2(DEPTH)-1:0] tbl_waddr,
    input  logic [ADDR_W-1:0]        tbl_wdata,
    output logic [ADDR_W-1:0]        core_addr,
    output logic                     core_go,
    input  logic [N_CORES-1:0]       core_done,
    input  logic [DATA_W-1:0]        core_result,
    output logic [DATA_W-1:0]        res_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [ADDR_W-1:0] tbl_q [DEPTH];
    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] core_addr_q, core_addr_d;
    logic              done_q, done_d;
    logic              push, full, empty;

`ifdef WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy      = is_busy(state_q);
    assign core_go   = state_q == S_ISSUE;
    assign core_addr = core_addr_q;
    assign done      = done_q;
    assign res_valid = !empty;

    // Table is frozen while a batch runs; no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (tbl_we && !busy) tbl_q[tbl_waddr] <= tbl_wdata;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        core_addr_d = core_addr_q;
        done_d      = 1'b0;
        push        = 1'b0;
`ifdef WATCHDOG_EN
        wd_d        = wd_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: if (start) begin
                cnt_d   = job_count;
                state_d = job_count != '0 ? S_READ : S_IDLE;
                done_d  = job_count == '0;
            end
            // core_addr_q doubles as the RAM's registered read port, so the address is
            // already stable when core_go fires in ISSUE.
            S_READ: begin
                core_addr_d = tbl_q[idx_q];
                state_d     = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef WATCHDOG_EN
                wd_d    = '0;
`endif
            end
            S_WAIT: if (&core_done) state_d = S_CAPTURE;
`ifdef WATCHDOG_EN
            else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                err_d   = 1'b1;
                state_d = S_DRAIN;
            end else wd_d = wd_q + WD_W'(1);
`endif
            S_CAPTURE: if (!full) begin
                push    = 1'b1;
                idx_d   = idx_q + IDX_W'(1);
                state_d = CNT_W'(idx_q) + CNT_W'(1) == cnt_q ? S_DRAIN : S_READ;
            end
            S_DRAIN: if (empty) begin
                done_d  = 1'b1;
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            core_addr_q <= '0;
            done_q      <= 1'b0;
`ifdef WATCHDOG_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            core_addr_q <= core_addr_d;
            done_q      <= done_d;
`ifdef WATCHDOG_EN
            wd_q        <= wd_d;
            err_q       <= err_d;
`endif
        end
    end

    seq_result_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (res_ready),
        .din   (core_result),
        .dout  (res_data),
        .full  (full),
        .empty (empty)
    );

endmodule
